ysyx22041207_mul: RTL and testbench

Iterative shift-add integer multiplier used by the ALU for RV64 MUL.
- Accepts two 64-bit operands through a valid/ready handshake.
- Computes the low 64 bits of the product over several cycles.
- Returns the product as two 32-bit halves with a one-cycle completion pulse.
- Supports pipeline flush (abort) from the core.

---
 rtl/ysyx22041207_mul.sv | 126 ++++++++++++
 tb/tb_ysyx22041207_mul.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041207_mul.sv
// Iterative shift-add multiplier producing the low 64 bits of a 64x64 product.
// Each BUSY cycle consumes BITS_PER_CYCLE multiplier bits (1, 2 or 4), so a
// full operation takes N = 64/BITS_PER_CYCLE cycles.
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all zero.
module ysyx22041207_mul #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_valid,
    input  logic        flush,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        mul_ready,
    output logic        out_valid,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    localparam int unsigned N    = 64 / BITS_PER_CYCLE;
    localparam int unsigned CntW = 7;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       mcand_q, mcand_d;
    logic [63:0]       mplier_q, mplier_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       result_q, result_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [63:0]       partial;
    logic [63:0]       acc_sum;
    logic [63:0]       mplier_shr;
    logic              last_iter;

    // Partial product for the low multiplier digit, plus the updated accumulator
    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        acc_sum    = acc_q + partial;
        mplier_shr = mplier_q >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_EXIT_EN
        last_iter  = (count_q == CntW'(N - 1)) || (mplier_shr == '0);
`else
        last_iter  = (count_q == CntW'(N - 1));
`endif
    end

    // Next-state logic: flush overrides acceptance and iteration
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        if (flush) begin
            // In-flight product is dropped; results keep their last value
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mul_valid) begin
                        mcand_d  = multiplicand;
                        mplier_d = multiplier;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = StBusy;
                    end
                end
                StBusy: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = mplier_shr;
                    count_d  = count_q + CntW'(1);
                    if (last_iter) begin
                        result_d = acc_sum;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // out_valid is a decode of the registered state, so it is glitch-free
    assign mul_ready = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result_hi = result_q[63:32];
    assign result_lo = result_q[31:0];

endmodule

// File: tb/tb_ysyx22041207_mul.sv
// Self-checking bench for ysyx22041207_mul: directed sequence with a result
// scoreboard (product and completion cycle) checked whenever out_valid is seen.
module tb_ysyx22041207_mul;

    localparam int unsigned BPC = 1;
    localparam int unsigned N   = 64 / BPC;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_valid;
    logic        flush;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_ready;
    logic        out_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    typedef struct {
        logic [63:0] prod;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    ysyx22041207_mul #(.BITS_PER_CYCLE(BPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected latency in cycles from the accepting edge to out_valid
    function automatic int unsigned lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < 64; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (unsigned'(msb) + BPC) / BPC;
`else
        return N + 0 * int'(b[0]);
`endif
    endfunction

    // Scoreboard monitor: every out_valid must match the oldest outstanding request
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {result_hi, result_lo}, e.prod);
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("ready_low_in_done", 64'(mul_ready), 64'd0);
            end
        end
    end

    // Called at posedge+1: wait for ready, issue a one-cycle request, log expectation
    task automatic req(input logic [63:0] a, input logic [63:0] b, input logic push);
        int n = 0;
        while (mul_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("ready_timeout", 64'(mul_ready), 64'd1);
        mul_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        if (push) sb.push_back('{prod: a * b, due: cyc + lat(b) + 1});
        #1;
        mul_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst          = 1'b1;
        mul_valid    = 1'b0;
        flush        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        @(posedge clk); #1;
        chk("reset_ready", 64'(mul_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", {result_hi, result_lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic product and ready return after DONE
        req(64'd3, 64'd5, 1'b1);
        drain();
        chk("ready_after_done", 64'(mul_ready), 64'd1);
        chk("result_hold", {result_hi, result_lo}, 64'hF);

        // Flush mid-operation: nothing reported, results keep 0xF
`ifdef MUL_EARLY_EXIT_EN
        req(64'd7, 64'h8000_0000_0000_0009, 1'b0);
`else
        req(64'd7, 64'd9, 1'b0);
`endif
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 64'(mul_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (70) @(posedge clk);
        #1;
        chk("flush_result_kept", {result_hi, result_lo}, 64'hF);

        // flush together with mul_valid in IDLE: no acceptance
        mul_valid = 1'b1; flush = 1'b1; multiplicand = 64'd11; multiplier = 64'd13;
        @(posedge clk); #1;
        mul_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 64'(mul_ready), 64'd1);

        // Wrap and truncation cases
        req(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
        drain();
        req(64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
        drain();
`ifdef MUL_EARLY_EXIT_EN
        req(64'h1234, 64'd1, 1'b1);
        drain();
        req(64'd5, 64'h80, 1'b1);
        drain();
        req(64'd99, 64'd0, 1'b1);
        drain();
`endif

        // mul_valid held with changing operands while busy, then back-to-back
        begin
            int n = 0;
            req(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b1);
            mul_valid = 1'b1;
            while (mul_ready !== 1'b1 && n < 300) begin
                multiplicand = {$urandom, $urandom};
                multiplier   = {$urandom, $urandom};
                @(posedge clk); #1; n++;
            end
            if (n >= 300) chk("b2b_timeout", 64'(mul_ready), 64'd1);
            mul_valid = 1'b0;
            req(64'hDEAD_BEEF, 64'hCAFE_F00D_1234_5678, 1'b1);
            drain();
        end

        // Random operands
        for (int k = 0; k < 4; k++) begin
            req({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            drain();
        end

        // Reset mid-operation clears results and drops the operation
        req(64'hABCD, 64'h8000_0000_0000_0003, 1'b1);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", {result_hi, result_lo}, 64'd0);
        chk("rst_ready", 64'(mul_ready), 64'd1);
        req(64'd6, 64'd7, 1'b1);
        drain();
        chk("post_rst_result", {result_hi, result_lo}, 64'h2A);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
